// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE -> ISSUE (ALU driven) -> RESP (held until accepted).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rda,
    input  logic [31:0] req0_rdb,
    input  logic [3:0]  req0_fop,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rda,
    input  logic [31:0] req1_rdb,
    input  logic [3:0]  req1_fop,
    output logic [31:0] alu_rda,
    output logic [31:0] alu_rdb,
    output logic [3:0]  alu_fop,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   op_id;
    logic   gnt;
    logic   any_req;
    logic   accept;

    // Grant selection, request handshakes and next-state decode
    always_comb begin
        any_req   = req0_valid | req1_valid;
        gnt       = 1'b0;
        state_nxt = state;
        if (req0_valid && req1_valid) begin
            gnt = prio;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end else begin
            gnt = 1'b0;
        end
        // Ready is gated by rst so nothing is handed over while reset is held
        accept     = (state == IDLE) && any_req && !rst;
        req0_ready = accept && !gnt;
        req1_ready = accept && gnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on grant; ALU inputs hold their last values afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= 1'b0;
            op_id   <= 1'b0;
            alu_rda <= 32'd0;
            alu_rdb <= 32'd0;
            alu_fop <= 4'd0;
        end else if (accept) begin
            prio    <= ~gnt;
            op_id   <= gnt;
            alu_rda <= gnt ? req1_rda : req0_rda;
            alu_rdb <= gnt ? req1_rdb : req0_rdb;
            alu_fop <= gnt ? req1_fop : req0_fop;
        end
    end

    // Response capture at the end of ISSUE, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
        end else if (state == ISSUE) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= op_id;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (32-bit operands, 4-bit function code, Z/N/C/V flags) between two requesters, the execute stage (port 0) and the address/branch unit (port 1). It registers the winning request, drives the ALU for exactly one cycle, captures result and flags, and returns them on a single valid/ready response channel tagged with the requester ID. Round-robin arbitration prevents starvation. One operation is in flight at a time.

## Interface
Parameters:
- none; data width fixed at 32, function code width fixed at 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_rda, req0_rdb  in  32 each  port 0 operands
- req0_fop  in  4  port 0 function code (0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 IMM)
- req1_valid, req1_ready, req1_rda, req1_rdb, req1_fop  same as port 0, for port 1
- alu_rda, alu_rdb  out  32 each  operands to ALU
- alu_fop  out  4  function code to ALU
- alu_result  in  32  ALU result (combinational from alu_* outputs)
- alu_flags  in  4  ALU flags {Z,N,C,V}, bit3 = Z, bit0 = V
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued this response
- rsp_result  out  32  captured result
- rsp_flags  out  4  captured flags {Z,N,C,V}

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if no req*_valid, stay. Otherwise grant one port:
  - only one valid → grant it.
  - both valid → grant port equal to prio.
  - req<g>_ready is combinational, asserted only in IDLE for the granted port. The non-granted port's ready = 0.
  - On grant: latch rda/rdb/fop into operand registers, latch grant ID, prio <= ~g, go ISSUE.
- ISSUE: alu_* driven from operand registers. At the clock edge, capture alu_result into rsp_result, alu_flags into rsp_flags, and the ID into rsp_id. Go RESP.
- RESP: rsp_valid = 1. On rsp_valid & rsp_ready, go IDLE. Otherwise hold, with rsp_* stable.
- alu_* always reflect operand registers and are stable outside ISSUE. They are not cleared after use.
- fop values 9–15 are passed through unmodified. The ALU defines the result (0) and the flags. No error signalling.
- No bypass: a request is never accepted in RESP or ISSUE, even when rsp_ready = 1.
- prio is updated only on a grant. It is not updated when a single requester wins while the other is idle, beyond the ~g rule above.

## Timing
- Reset values: state IDLE, prio 0, operand registers 0 (alu_rda = alu_rdb = 0, alu_fop = 0), rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0. req*_ready is 0 during reset.
- Latency: request accepted at edge N (valid & ready high in cycle N-1→N) → ISSUE in cycle N → rsp_valid high from edge N+1.
- Minimum throughput: 1 operation per 3 cycles (IDLE, ISSUE, RESP with rsp_ready = 1).
- Requesters must hold valid and operands stable until ready. Dropping valid before grant is permitted and loses nothing.
- Reset asserted in any state: immediately return to IDLE. Any in-flight response is discarded and rsp_valid drops asynchronously.
- Both ports are valid continuously: grants strictly alternate 0,1,0,1… starting with 0 after reset.

## Test plan
- Single request: port 0 ADD, rda = 10, rdb = 5 → req0_ready one cycle. Two edges later rsp_valid = 1, rsp_id = 0, rsp_result = 15, rsp_flags = 4'b0000.
- Overflow/flags: port 1 ADD 0x7FFFFFFF + 1 → rsp_id = 1, rsp_result = 0x80000000, rsp_flags = 4'b0101 (N = 1, V = 1). Then port 1 SUB 123456789 − 123456789 → rsp_result = 0, Z = 1.
- Arbitration: after reset, hold both valid with distinct ops (port 0 AND 0xF0F0 & 0xFF00, port 1 OR 0x1 | 0x2) for 4 transactions → rsp_id sequence 0,1,0,1 with results 0xF000, 0x3, 0xF000, 0x3. No ready is asserted on the losing port.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid and rsp_* stay constant. Both req*_ready stay 0. The next grant occurs only in the cycle after the response handshake.
- Reset mid-operation: assert rst during ISSUE, then again during RESP → rsp_valid = 0 immediately and all outputs at reset values. After release, a new port 1 SLL 1 << 31 request completes with rsp_result = 0x80000000.
- Invalid fop: port 0 fop = 12, rda = 5, rdb = 7 → rsp_result = 0 and rsp_flags Z = 1, passed through from the ALU.
